// File: rtl/wb_ps2.sv
// PS/2 receiver with Wishbone DATA/STATUS registers, receive FIFO and level irq.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking (perr).
module wb_ps2 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 200000,
  parameter int FILTER_LEN = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        irq,
  input  logic        ps2_clk,
  input  logic        ps2_dat
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FILTER_LEN - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitn_q, bitn_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          push_q, push_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
  logic          irq_en_q, irq_en_d, irq_q, irq_d, ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic          sample, parity_bad, ferr_set, perr_set;
  logic          req, pop, do_push, full, nempty;
  logic [2:0]    clr;
  logic [8:0]    cnt9;
  logic [7:0]    cnt8;
  logic [31:0]   status;
  logic          unused_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_bad = ~^{shreg_q, par_q};
`else
  assign parity_bad = 1'b0;
`endif
  assign unused_ok = ^{dat_i[31:9], dat_i[7:5], dat_i[1:0], sel_i[3:2], par_q};

  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_dat;
    dat_s2_d = dat_s1_q;
    filt_d   = filt_q;
    fcnt_d   = '0;
    // the filtered level flips on the FILTER_LEN-th consecutive differing sample
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FL_LAST) filt_d = clk_s2_q;
      else                   fcnt_d = fcnt_q + 1'b1;
    end
    sample = filt_q & ~filt_d;

    state_d  = state_q;
    bitn_d   = bitn_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    if (state_q == S_IDLE || sample) timer_d = '0;
    else                             timer_d = timer_q + 1'b1;

    case (state_q)
      S_IDLE: if (sample && !dat_s2_q) begin
        state_d = S_DATA;
        bitn_d  = '0;
      end
      S_DATA: if (sample) begin
        shreg_d = {dat_s2_q, shreg_q[7:1]};
        bitn_d  = bitn_q + 1'b1;
        if (bitn_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (sample) begin
        par_d   = dat_s2_q;
        state_d = S_STOP;
      end
      S_STOP: if (sample) begin
        state_d = S_IDLE;
        if (!dat_s2_q)       ferr_set = 1'b1;
        else if (parity_bad) perr_set = 1'b1;
        else                 push_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !sample && timer_q == TO_LAST) begin
      state_d  = S_IDLE;
      ferr_set = 1'b1;
    end

    full   = (count_q == DEPTH_C);
    nempty = (count_q != '0);
    cnt9   = 9'(count_q);
    cnt8   = cnt9[8] ? 8'hFF : cnt9[7:0];
    status = {8'd0, cnt8, 7'd0, irq_en_q, 3'd0, ferr_q, perr_q, ovr_q, full, nempty};

    req      = cyc_i & stb_i & ~ack_q;
    ack_d    = req;
    dat_d    = '0;
    pop      = 1'b0;
    irq_en_d = irq_en_q;
    clr      = '0;
    if (req && !we_i) begin
      if (adr_i)       dat_d = status;
      else if (nempty) dat_d = {24'd0, mem[rd_ptr_q]};
      pop = ~adr_i & nempty;
    end
    if (req && we_i && adr_i && (sel_i[1] | sel_i[0])) begin
      irq_en_d = dat_i[8];
      clr      = dat_i[4:2];
    end

    // a pop in the same cycle frees the slot, so a push on full still lands
    do_push  = push_q & (~full | pop);
    ovr_d    = (ovr_q  & ~clr[0]) | (push_q & full & ~pop);
    perr_d   = (perr_q & ~clr[1]) | perr_set;
    ferr_d   = (ferr_q & ~clr[2]) | ferr_set;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !pop)      count_d = count_q + 1'b1;
    else if (!do_push && pop) count_d = count_q - 1'b1;
    irq_d = irq_en_q & nempty;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      timer_q  <= '0;
      bitn_q   <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      push_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      clk_s1_q <= clk_s1_d;
      clk_s2_q <= clk_s2_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      timer_q  <= timer_d;
      bitn_q   <= bitn_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      push_q   <= push_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;
  assign irq   = irq_q;
endmodule

// File: tb/tb_wb_ps2.sv
// Self-checking bench for wb_ps2: queue/flag model of the register file, directed PS/2 frames.
module tb_wb_ps2;
  localparam int DEPTH = 4;
  localparam int TMO   = 300;
  localparam int FLEN  = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dati = '0;
  logic        ack;
  logic [31:0] dato;
  logic        irq;
  logic        ps2c = 1'b1, ps2d = 1'b1;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];
  bit m_ovr, m_perr, m_ferr, m_irqen;
  logic [31:0] exp_dat;
  bit exp_pending = 1'b0;
  bit exp_read    = 1'b0;

  wb_ps2 #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .FILTER_LEN(FLEN)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dati), .ack_o(ack), .dat_o(dato), .irq(irq),
    .ps2_clk(ps2c), .ps2_dat(ps2d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = q.size() != 0;
    s[1]    = q.size() == DEPTH;
    s[2]    = m_ovr;
    s[3]    = m_perr;
    s[4]    = m_ferr;
    s[8]    = m_irqen;
    s[23:16] = 8'(q.size());
    return s;
  endfunction

  // Compare process: every ack must be one the bench asked for; reads must match the model.
  always @(negedge clk) begin
    if (ack) begin
      if (exp_pending) begin
        if (exp_read) chk("dat_o", dato, exp_dat);
        exp_pending = 1'b0;
      end else begin
        chk("unexpected_ack", 32'(ack), 32'd0);
      end
    end
  end

  task automatic wb_xfer(input bit w, input bit a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 5);
    chk("ack_latency", 32'(n), 32'd1);
    rd  = dato;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); #1;
    @(posedge clk); #1;
    chk("ack_single", 32'(ack), 32'd0);
    exp_pending = 1'b0;
  endtask

  task automatic wb_read(input bit a, output logic [31:0] rd);
    if (a) exp_dat = m_status();
    else   exp_dat = (q.size() != 0) ? {24'd0, q.pop_front()} : 32'd0;
    exp_read    = 1'b1;
    exp_pending = 1'b1;
    wb_xfer(1'b0, a, '0, '0, rd);
  endtask

  task automatic wb_write(input bit a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    exp_read    = 1'b0;
    exp_pending = 1'b1;
    wb_xfer(1'b1, a, d, s, dummy);
    if (a && (s[1] | s[0])) begin
      m_irqen = d[8];
      if (d[2]) m_ovr  = 1'b0;
      if (d[3]) m_perr = 1'b0;
      if (d[4]) m_ferr = 1'b0;
    end
  endtask

  task automatic ps2_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = fr[i];
      repeat (5) @(posedge clk);
      #1 ps2c = 1'b0;
      repeat (10) @(posedge clk);
      #1 ps2c = 1'b1;
      repeat (5) @(posedge clk);
    end
    #1 ps2d = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    bit bad_par;
    ps2_bits({stp, par, b, 1'b0}, 11);
    repeat (20) @(posedge clk);
`ifdef PS2_PARITY_CHECK_EN
    bad_par = ((^b) ^ par) == 1'b0;
`else
    bad_par = 1'b0;
`endif
    if (!stp)                  m_ferr = 1'b1;
    else if (bad_par)          m_perr = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else                       q.push_back(b);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 0; m_perr = 0; m_ferr = 0; m_irqen = 0;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_dat", dato, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    wb_read(1'b1, rd);
    chk("reset_status", rd, 32'h0);

    // 0x1C, odd parity bit 0
    send_frame(8'h1C, 1'b0, 1'b1);
    wb_read(1'b1, rd);
    chk("status_one", rd, 32'h0001_0001);
    wb_read(1'b0, rd);
    chk("data_1c", rd, 32'h0000_001C);
    wb_read(1'b1, rd);
    chk("status_empty_bit0", 32'(rd[0]), 32'd0);
    wb_read(1'b0, rd);
    chk("data_empty", rd, 32'h0);

    // writes ignored without byte selects 0/1, then irq enable
    wb_write(1'b1, 32'h100, 4'b1100);
    wb_read(1'b1, rd);
    chk("sel_ignored", 32'(rd[8]), 32'd0);
    wb_write(1'b1, 32'h100, 4'b0011);
    send_good(8'hF0);
    chk("irq_rise", 32'(irq), 32'd1);
    wb_read(1'b0, rd);
    chk("data_f0", rd, 32'h0000_00F0);
    repeat (2) @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 32'd0);

    // overflow: DEPTH+1 frames with no reads
    for (int i = 0; i <= DEPTH; i++) send_good(8'(8'h10 + i));
    wb_read(1'b1, rd);
    chk("status_full_ovr", rd, 32'h0004_0107);
    for (int i = 0; i < DEPTH; i++) begin
      wb_read(1'b0, rd);
      chk("fifo_order", rd, 32'(8'h10 + i));
    end
    wb_write(1'b1, 32'h104, 4'b0001);
    wb_read(1'b1, rd);
    chk("ovr_cleared", rd, 32'h0000_0100);

    // bad parity frame
    send_frame(8'h1C, 1'b1, 1'b1);
    wb_read(1'b1, rd);
`ifdef PS2_PARITY_CHECK_EN
    chk("perr_set", 32'(rd[3]), 32'd1);
    chk("perr_no_push", 32'(rd[0]), 32'd0);
`else
    chk("perr_ignored", 32'(rd[3]), 32'd0);
`endif
    wb_write(1'b1, 32'h8, 4'b0011);
    wb_read(1'b1, rd);
    chk("perr_clear", 32'(rd[3]), 32'd0);
    wb_read(1'b0, rd);

    // stop bit 0
    send_frame(8'h33, ~^8'h33, 1'b0);
    wb_read(1'b1, rd);
    chk("ferr_stop", rd, 32'h0000_0010);
    wb_write(1'b1, 32'h10, 4'b0011);

    // timeout after start + 4 data bits
    ps2_bits({2'b11, 8'h0F, 1'b0}, 5);
    repeat (TMO + 50) @(posedge clk);
    m_ferr = 1'b1;
    wb_read(1'b1, rd);
    chk("ferr_timeout", rd, 32'h0000_0010);
    send_good(8'h5A);
    wb_read(1'b0, rd);
    chk("data_5a", rd, 32'h0000_005A);

    // 3-cycle low glitch while idle with data low
    @(posedge clk); #1;
    ps2d = 1'b0; ps2c = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2c = 1'b1; ps2d = 1'b1;
    repeat (20) @(posedge clk);
    wb_read(1'b1, rd);
    send_good(8'hA5);
    wb_read(1'b0, rd);
    chk("data_a5", rd, 32'h0000_00A5);

    // reset in the middle of a frame
    wb_write(1'b1, 32'h100, 4'b0011);
    send_good(8'h77);
    ps2_bits({2'b11, 8'h99, 1'b0}, 4);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("midreset_irq", 32'(irq), 32'd0);
    wb_read(1'b1, rd);
    chk("midreset_status", rd, 32'h0);
    send_good(8'h3C);
    wb_read(1'b0, rd);
    chk("data_3c", rd, 32'h0000_003C);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_ps2.md
WB_PS2 -- requirements
Module: wb_ps2

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, receive FIFO depth in bytes; power of two, 2..256.
REQ-002 Parameter TIMEOUT, default 200000, clk_i cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-003 Parameter FILTER_LEN, default 8, clk_i cycles a synchronized ps2_clk level must be stable before it is accepted.
REQ-004 clk_i  input  1  system clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous to clk_i, active-high.
REQ-006 cyc_i  input  1  Wishbone cycle.
REQ-007 stb_i  input  1  Wishbone strobe, block select.
REQ-008 we_i  input  1  Wishbone write enable.
REQ-009 adr_i  input  1  word address: 0 = DATA, 1 = STATUS.
REQ-010 sel_i  input  4  byte selects; writes honoured only when sel_i[1] or sel_i[0] is set.
REQ-011 dat_i  input  32  write data.
REQ-012 ack_o  output  1  Wishbone acknowledge.
REQ-013 dat_o  output  32  read data.
REQ-014 irq  output  1  level interrupt to irqc.
REQ-015 ps2_clk  input  1  PS/2 clock from the device, asynchronous.
REQ-016 ps2_dat  input  1  PS/2 data from the device, asynchronous.

Function
REQ-017 ps2_clk and ps2_dat SHALL each pass a 2-flop synchronizer; the filtered clock SHALL change only after FILTER_LEN consecutive equal synchronized samples.
REQ-018 A 1->0 transition of the filtered clock SHALL be a sample event; ps2_dat is captured at that event.
REQ-019 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: a sample with dat=0 (start) SHALL go to DATA; a sample with dat=1 SHALL be ignored.
REQ-021 DATA: 8 samples SHALL shift the data bits in LSB first, then go to PARITY.
REQ-022 PARITY: one sample SHALL capture the parity bit, then go to STOP.
REQ-023 STOP: one sample SHALL return to IDLE; the byte SHALL be pushed only if stop=1 and the parity check passes (REQ-036).
REQ-024 On stop=0, the byte SHALL be discarded and STATUS.ferr set.
REQ-025 In any state other than IDLE, TIMEOUT cycles without a sample event SHALL return the FSM to IDLE, discard the partial byte and set ferr.
REQ-026 Push SHALL occur in the cycle after the STOP sample.
REQ-027 Push when the FIFO is full with no pop in the same cycle SHALL drop the byte and set STATUS.ovr.
REQ-028 Simultaneous push and pop on a full FIFO SHALL both succeed.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-030 ack_o SHALL assert exactly one cycle after cyc_i&stb_i&!ack_o, for one cycle; no back-to-back ack.
REQ-031 DATA read: dat_o = {24'd0, head byte}, and the FIFO SHALL pop on the ack cycle; an empty FIFO returns 0 with no pop. DATA writes are ignored.
REQ-032 STATUS read fields: bit0 not-empty; bit1 full; bit2 ovr; bit3 perr; bit4 ferr; bit8 irq_en; bits[23:16] count; all other bits 0.
REQ-033 STATUS write: bit8 loads irq_en; writing 1 to bits 2, 3 or 4 clears that sticky flag; a clear and a set in the same cycle SHALL leave the flag set.
REQ-034 irq = irq_en & not-empty, registered.

Reset
REQ-035 rst_i SHALL force FSM=IDLE, FIFO empty, ovr=perr=ferr=0, irq_en=0, ack_o=0, dat_o=0, irq=0 and the filter state to 1, aborting any frame in progress; the next frame SHALL be received normally.

Configuration
REQ-036 With PS2_PARITY_CHECK_EN defined, a frame whose 8 data bits plus parity bit have even parity SHALL be discarded and perr set; without the macro, the parity bit SHALL be ignored and perr SHALL read 0.

Verification
REQ-037 Frame 0x1C with odd parity bit=0 -> DATA read returns 0x0000001C, STATUS.bit0 is 0 afterwards.
REQ-038 irq_en=1, frame 0xF0 -> irq rises; one DATA read -> irq falls.
REQ-039 FIFO_DEPTH+1 frames with no reads -> full=1, ovr=1, count=FIFO_DEPTH; the first FIFO_DEPTH bytes read back in order.
REQ-040 With PS2_PARITY_CHECK_EN, frame 0x1C with parity bit=1 -> no push, perr=1; writing STATUS 0x8 -> perr=0.
REQ-041 ps2_clk stops after 4 data bits for TIMEOUT+1 cycles -> ferr=1, FSM=IDLE; the next full frame 0x5A is received correctly.
REQ-042 A 3-cycle low glitch on ps2_clk while IDLE -> no sample event, no state change.
